// File: rtl/alu_pkg.sv
// Shared ALU/controller types: opcode and funct constants, controller states.
// HALT state is only reachable when MIPS_CTRL_HALT_EN is defined.
package alu_pkg;

    localparam logic [5:0] RTYPE     = 6'h00;

    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_SLTI   = 6'h0A;
    localparam logic [5:0] OP_SLTIU  = 6'h0B;
    localparam logic [5:0] OP_XORI   = 6'h0E;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2B;
    localparam logic [5:0] OP_HALT   = 6'h3F;

    typedef enum logic [5:0] {
        F_SLL   = 6'h00,
        F_SRL   = 6'h02,
        F_SRA   = 6'h03,
        F_JR    = 6'h08,
        F_MFHI  = 6'h10,
        F_MFLO  = 6'h12,
        F_MULT  = 6'h18,
        F_MULTU = 6'h19,
        F_ADDU  = 6'h21,
        F_SUBU  = 6'h23,
        F_AND   = 6'h24,
        F_OR    = 6'h25,
        F_XOR   = 6'h26,
        F_NOR   = 6'h27,
        F_SLT   = 6'h2A,
        F_SLTU  = 6'h2B
    } r_sel_t;

    typedef enum logic [3:0] {
        INIT,
        FETCH,
        FETCH_WAIT,
        DECODE,
        MEM_ADDR,
        MEM_RD,
        MEM_RD_WAIT,
        MEM_WB,
        MEM_WR,
        R_EXEC,
        R_WB,
        I_EXEC,
        I_WB,
        BRANCH,
        JUMP,
        HALT
    } ctrl_state_t;

    function automatic logic is_imm_op(input logic [5:0] op);
        return op inside {[OP_ADDIU:OP_XORI]};
    endfunction

    function automatic logic is_branch_op(input logic [5:0] op);
        return (op == OP_REGIMM) || (op inside {[OP_BEQ:OP_BGTZ]});
    endfunction

    function automatic logic is_jump_op(input logic [5:0] op);
        return (op == OP_J) || (op == OP_JAL);
    endfunction

    // Arithmetic immediates sign-extend; logical ones zero-extend.
    function automatic logic imm_signed(input logic [5:0] op);
        return op inside {OP_ADDIU, OP_SLTI, OP_SLTIU};
    endfunction

endpackage

// File: rtl/mips_ctrl_fsm_if.sv
// Controller <-> datapath bundle: IR fields in, mux selects and strobes out.
interface mips_ctrl_fsm_if;

    logic [5:0] ir_opcode;
    logic [5:0] ir_funct;
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       jump_and_link;
    logic       is_signed;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [5:0] alu_op;
    logic       halted;

    modport master (
        input  ir_opcode, ir_funct,
        output pc_write, pc_write_cond, i_or_d, mem_write, ir_write,
        output mem_to_reg, reg_dst, reg_write, jump_and_link, is_signed,
        output alu_src_a, alu_src_b, pc_source, alu_op, halted
    );

    modport slave (
        output ir_opcode, ir_funct,
        input  pc_write, pc_write_cond, i_or_d, mem_write, ir_write,
        input  mem_to_reg, reg_dst, reg_write, jump_and_link, is_signed,
        input  alu_src_a, alu_src_b, pc_source, alu_op, halted
    );

endinterface

// File: rtl/mips_ctrl_fsm.sv
// Multi-cycle MIPS main controller (Moore FSM).
// Define MIPS_CTRL_HALT_EN to build the HALT state for HALT_OPCODE.
module mips_ctrl_fsm
    import alu_pkg::*;
#(
    parameter logic [5:0] HALT_OPCODE = OP_HALT
) (
    input  logic           clk,
    input  logic           rst,
    mips_ctrl_fsm_if.master bus
);

    ctrl_state_t state;
    ctrl_state_t nxt;
    logic        init_done;
    logic [5:0]  op;
    r_sel_t      fn;
    logic        halt_hit;

    assign op       = bus.ir_opcode;
    assign fn       = r_sel_t'(bus.ir_funct);
    assign halt_hit = (op == HALT_OPCODE);

    // INIT is held for one full cycle after reset release before fetching.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= INIT;
            init_done <= 1'b0;
        end else begin
            state     <= nxt;
            init_done <= 1'b1;
        end
    end

    always_comb begin
        nxt = state;
        unique case (state)
            INIT:        if (init_done) nxt = FETCH;
            FETCH:       nxt = FETCH_WAIT;
            FETCH_WAIT:  nxt = DECODE;
            DECODE: begin
                nxt = FETCH;
                if (halt_hit) begin
`ifdef MIPS_CTRL_HALT_EN
                    nxt = HALT;
`else
                    nxt = FETCH;
`endif
                end else begin
                    unique case (1'b1)
                        op == RTYPE:                  nxt = R_EXEC;
                        op == OP_LW || op == OP_SW:   nxt = MEM_ADDR;
                        is_imm_op(op):                nxt = I_EXEC;
                        is_branch_op(op):             nxt = BRANCH;
                        is_jump_op(op):               nxt = JUMP;
                        default:                      nxt = FETCH;
                    endcase
                end
            end
            MEM_ADDR:    nxt = (op == OP_SW) ? MEM_WR : MEM_RD;
            MEM_RD:      nxt = MEM_RD_WAIT;
            MEM_RD_WAIT: nxt = MEM_WB;
            MEM_WB:      nxt = FETCH;
            MEM_WR:      nxt = FETCH;
            R_EXEC: begin
                if (fn == F_JR || fn == F_MULT || fn == F_MULTU)
                    nxt = FETCH;
                else
                    nxt = R_WB;
            end
            R_WB:        nxt = FETCH;
            I_EXEC:      nxt = I_WB;
            I_WB:        nxt = FETCH;
            BRANCH:      nxt = FETCH;
            JUMP:        nxt = FETCH;
`ifdef MIPS_CTRL_HALT_EN
            HALT:        nxt = HALT;
`endif
            default:     nxt = INIT;
        endcase
    end

    always_comb begin
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.i_or_d        = 1'b0;
        bus.mem_write     = 1'b0;
        bus.ir_write      = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.reg_dst       = 1'b0;
        bus.reg_write     = 1'b0;
        bus.jump_and_link = 1'b0;
        bus.is_signed     = 1'b0;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = 2'd0;
        bus.pc_source     = 2'd0;
        bus.alu_op        = OP_ADDIU;
        bus.halted        = 1'b0;
        unique case (state)
            FETCH: begin
                bus.alu_src_b = 2'd1;
                bus.pc_write  = 1'b1;
            end
            FETCH_WAIT: bus.ir_write = 1'b1;
            // Precompute PC + (imm << 2) so a branch finds its target in ALUOut.
            DECODE: begin
                bus.alu_src_b = 2'd3;
                bus.is_signed = 1'b1;
            end
            MEM_ADDR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'd2;
                bus.is_signed = 1'b1;
            end
            MEM_RD: bus.i_or_d = 1'b1;
            MEM_WB: begin
                bus.mem_to_reg = 1'b1;
                bus.reg_write  = 1'b1;
            end
            MEM_WR: begin
                bus.i_or_d    = 1'b1;
                bus.mem_write = 1'b1;
            end
            R_EXEC: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = RTYPE;
                if (fn == F_JR) bus.pc_write = 1'b1;
            end
            R_WB: begin
                bus.reg_dst   = 1'b1;
                bus.reg_write = 1'b1;
                bus.alu_op    = RTYPE;
            end
            I_EXEC: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'd2;
                bus.alu_op    = op;
                bus.is_signed = imm_signed(op);
            end
            I_WB: bus.reg_write = 1'b1;
            BRANCH: begin
                bus.alu_src_a     = 1'b1;
                bus.alu_op        = op;
                bus.pc_source     = 2'd1;
                bus.pc_write_cond = 1'b1;
            end
            JUMP: begin
                bus.pc_source = 2'd2;
                bus.pc_write  = 1'b1;
                if (op == OP_JAL) begin
                    bus.jump_and_link = 1'b1;
                    bus.reg_write     = 1'b1;
                end
            end
`ifdef MIPS_CTRL_HALT_EN
            HALT: bus.halted = 1'b1;
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mips_ctrl_fsm.sv
// Directed bench for mips_ctrl_fsm: per-cycle control words vs hand-made table.
// Follows MIPS_CTRL_HALT_EN for the 6'h3F case.
module tb_mips_ctrl_fsm;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    mips_ctrl_fsm_if bus();

    mips_ctrl_fsm dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Word = {pw pwc iod mw | irw m2r rd rw | jal sg sa, src_b, pc_src, alu_op, halted}
    localparam logic [21:0] W_INIT = {11'b0000_0000_000, 2'd0, 2'd0, 6'h09, 1'b0};
    localparam logic [21:0] W_F    = {11'b1000_0000_000, 2'd1, 2'd0, 6'h09, 1'b0};
    localparam logic [21:0] W_FW   = {11'b0000_1000_000, 2'd0, 2'd0, 6'h09, 1'b0};
    localparam logic [21:0] W_D    = {11'b0000_0000_010, 2'd3, 2'd0, 6'h09, 1'b0};
    localparam logic [21:0] W_REX  = {11'b0000_0000_001, 2'd0, 2'd0, 6'h00, 1'b0};
    localparam logic [21:0] W_RJR  = {11'b1000_0000_001, 2'd0, 2'd0, 6'h00, 1'b0};
    localparam logic [21:0] W_RWB  = {11'b0000_0011_000, 2'd0, 2'd0, 6'h00, 1'b0};
    localparam logic [21:0] W_MA   = {11'b0000_0000_011, 2'd2, 2'd0, 6'h09, 1'b0};
    localparam logic [21:0] W_MRD  = {11'b0010_0000_000, 2'd0, 2'd0, 6'h09, 1'b0};
    localparam logic [21:0] W_MRW  = {11'b0000_0000_000, 2'd0, 2'd0, 6'h09, 1'b0};
    localparam logic [21:0] W_MWB  = {11'b0000_0101_000, 2'd0, 2'd0, 6'h09, 1'b0};
    localparam logic [21:0] W_MWR  = {11'b0011_0000_000, 2'd0, 2'd0, 6'h09, 1'b0};
    localparam logic [21:0] W_BEQ  = {11'b0100_0000_001, 2'd0, 2'd1, 6'h04, 1'b0};
    localparam logic [21:0] W_JAL  = {11'b1000_0001_100, 2'd0, 2'd2, 6'h09, 1'b0};
    localparam logic [21:0] W_J    = {11'b1000_0000_000, 2'd0, 2'd2, 6'h09, 1'b0};
    localparam logic [21:0] W_ORI  = {11'b0000_0000_001, 2'd2, 2'd0, 6'h0D, 1'b0};
    localparam logic [21:0] W_SLTI = {11'b0000_0000_011, 2'd2, 2'd0, 6'h0A, 1'b0};
    localparam logic [21:0] W_IWB  = {11'b0000_0001_000, 2'd0, 2'd0, 6'h09, 1'b0};
    localparam logic [21:0] W_HALT = {11'b0000_0000_000, 2'd0, 2'd0, 6'h09, 1'b1};

    logic [21:0] snap;
    logic [21:0] seq[$];

    assign snap = {bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_write,
                   bus.ir_write, bus.mem_to_reg, bus.reg_dst, bus.reg_write,
                   bus.jump_and_link, bus.is_signed, bus.alu_src_a,
                   bus.alu_src_b, bus.pc_source, bus.alu_op, bus.halted};

    task automatic check(input string tag, input logic [21:0] got,
                         input logic [21:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %06h want %06h", tag, got, exp);
        end
    endtask

    // Called at a negedge while in FETCH; leaves at the next FETCH negedge.
    task automatic run(input string tag, input logic [5:0] op,
                       input logic [5:0] fn);
        bus.ir_opcode = op;
        bus.ir_funct  = fn;
        foreach (seq[i]) begin
            check($sformatf("%s[%0d]", tag, i), snap, seq[i]);
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_async", snap, W_INIT);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("init_hold", snap, W_INIT);
        @(negedge clk);
    endtask

    initial begin
        bus.ir_opcode = 6'h00;
        bus.ir_funct  = 6'h21;
        repeat (2) @(negedge clk);
        do_reset();

        seq = '{W_F, W_FW, W_D, W_REX, W_RWB};
        run("addu", 6'h00, 6'h21);
        seq = '{W_F, W_FW, W_D, W_MA, W_MRD, W_MRW, W_MWB};
        run("lw", 6'h23, 6'h00);
        seq = '{W_F, W_FW, W_D, W_MA, W_MWR};
        run("sw", 6'h2B, 6'h00);
        seq = '{W_F, W_FW, W_D, W_BEQ};
        run("beq", 6'h04, 6'h00);
        seq = '{W_F, W_FW, W_D, W_JAL};
        run("jal", 6'h03, 6'h00);
        seq = '{W_F, W_FW, W_D, W_J};
        run("j", 6'h02, 6'h00);
        seq = '{W_F, W_FW, W_D, W_RJR};
        run("jr", 6'h00, 6'h08);
        seq = '{W_F, W_FW, W_D, W_REX};
        run("mult", 6'h00, 6'h18);
        seq = '{W_F, W_FW, W_D, W_ORI, W_IWB};
        run("ori", 6'h0D, 6'h00);
        seq = '{W_F, W_FW, W_D, W_SLTI, W_IWB};
        run("slti", 6'h0A, 6'h00);
        seq = '{W_F, W_FW, W_D};
        run("ill3e", 6'h3E, 6'h00);
        seq = '{W_F, W_FW, W_D};
        run("op3f", 6'h3F, 6'h00);
`ifdef MIPS_CTRL_HALT_EN
        for (int i = 0; i < 20; i++) begin
            check($sformatf("halt[%0d]", i), snap, W_HALT);
            @(negedge clk);
        end
        do_reset();
`endif
        seq = '{W_F, W_FW, W_D, W_MA};
        run("sw_rst", 6'h2B, 6'h00);
        check("sw_rst_mwr", snap, W_MWR);
        do_reset();
        seq = '{W_F, W_FW, W_D, W_REX, W_RWB};
        run("addu2", 6'h00, 6'h21);
        check("tail_fetch", snap, W_F);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mips_ctrl_fsm.md
# mips_ctrl_fsm

Multi-cycle main controller for the MIPS datapath. It sequences the shared ALU, memory, instruction register, register file and PC through fetch, decode, execute, memory and write-back steps. It decodes `ir_opcode`/`ir_funct` and drives the datapath mux selects and enables. It drives the 6-bit `alu_op` that the ALU-control decoder consumes, using `RTYPE` for R-type instructions.

## Interface
Parameters:
- `HALT_OPCODE`, default `6'h3F`: opcode that parks the machine (see Configuration).

Ports:
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `ir_opcode`  in  6  IR[31:26], valid from DECODE onward
- `ir_funct`  in  6  IR[5:0]
- `pc_write`  out  1  unconditional PC load
- `pc_write_cond`  out  1  PC load gated by the ALU branch-taken flag
- `i_or_d`  out  1  memory address select: 0 = PC, 1 = ALUOut
- `mem_write`  out  1  memory write strobe
- `ir_write`  out  1  IR load enable
- `mem_to_reg`  out  1  register write data select: 0 = ALUOut, 1 = MDR
- `reg_dst`  out  1  destination select: 0 = rt, 1 = rd
- `reg_write`  out  1  register file write enable
- `jump_and_link`  out  1  force destination to r31 and data to PC
- `is_signed`  out  1  sign-extend the immediate (0 = zero-extend)
- `alu_src_a`  out  1  0 = PC, 1 = RegA
- `alu_src_b`  out  2  0 = RegB, 1 = 4, 2 = imm, 3 = imm<<2
- `pc_source`  out  2  0 = ALU result, 1 = ALUOut, 2 = jump target
- `alu_op`  out  6  opcode presented to ALU control
- `halted`  out  1  controller parked in HALT

## Operation
- Moore FSM. All outputs decode from the state, plus the latched opcode/funct where noted.
- States:
  - INIT
  - FETCH, FETCH_WAIT
  - DECODE
  - MEM_ADDR, MEM_RD, MEM_RD_WAIT, MEM_WB, MEM_WR
  - R_EXEC, R_WB
  - I_EXEC, I_WB
  - BRANCH, JUMP
  - HALT
- Default in every state: all strobes 0, `alu_op` = ADDIU (`6'h09`), and every select 0.
- INIT → FETCH unconditionally.
- FETCH: `i_or_d`=0, `alu_src_a`=0, `alu_src_b`=1, `pc_source`=0, `pc_write`=1. Next is FETCH_WAIT.
- FETCH_WAIT: `ir_write`=1. Next is DECODE.
- DECODE: `alu_src_a`=0, `alu_src_b`=3, `is_signed`=1, so the branch target lands in ALUOut. Dispatch on opcode:
  - `6'h00` → R_EXEC
  - `6'h23` (LW) or `6'h2B` (SW) → MEM_ADDR
  - `6'h09`, `6'h0A`, `6'h0B`, `6'h0C`, `6'h0D`, `6'h0E` → I_EXEC
  - `6'h01`, `6'h04`–`6'h07` → BRANCH
  - `6'h02` or `6'h03` → JUMP
  - `HALT_OPCODE` → HALT when enabled
  - anything else → FETCH (treated as a NOP)
- MEM_ADDR: `alu_src_a`=1, `alu_src_b`=2, `is_signed`=1. Next is MEM_RD for LW, MEM_WR for SW.
- MEM_RD: `i_or_d`=1. Next is MEM_RD_WAIT, then MEM_WB.
- MEM_WB: `mem_to_reg`=1, `reg_write`=1, `reg_dst`=0.
- MEM_WR: `i_or_d`=1, `mem_write`=1.
- R_EXEC: `alu_src_a`=1, `alu_src_b`=0, `alu_op`=`RTYPE`.
  - funct JR: `pc_write`=1, `pc_source`=0, then FETCH.
  - funct MULT/MULTU (`6'h18`/`6'h19`): FETCH, since HI/LO load inside the ALU stage.
  - Otherwise R_WB.
- R_WB: `reg_dst`=1, `reg_write`=1, `alu_op`=`RTYPE`.
- I_EXEC: `alu_src_a`=1, `alu_src_b`=2, `alu_op`=opcode. `is_signed`=1 for `6'h09`/`6'h0A`/`6'h0B`, 0 for the logical immediates.
- I_WB: `reg_dst`=0, `reg_write`=1.
- BRANCH: `alu_src_a`=1, `alu_src_b`=0, `alu_op`=opcode, `pc_source`=1, `pc_write_cond`=1.
- JUMP: `pc_source`=2, `pc_write`=1. For JAL additionally `jump_and_link`=1 and `reg_write`=1.
- Every terminal state returns to FETCH.

## Timing
- Reset: asynchronous entry to INIT. While in INIT all outputs are 0 and `alu_op`=`6'h09`. First FETCH occurs on the second rising edge after `rst` falls.
- Cycles per instruction, FETCH through the last state:
  - branch, jump, JR, MULT: 4
  - R-type, I-type, SW: 5
  - LW: 7
- Memory read latency is 1 cycle. Hence FETCH_WAIT and MEM_RD_WAIT exist.
- Opcode and funct are sampled in DECODE and later states from the IR. The IR is stable because `ir_write` is only high in FETCH_WAIT.
- Asserting `rst` mid-instruction forces INIT immediately. Partial stores are not completed. `mem_write` drops asynchronously with reset.

## Configuration
- `MIPS_CTRL_HALT_EN` defined:
  - `HALT_OPCODE` in DECODE enters HALT.
  - HALT holds all strobes at 0, `halted`=1, and is left only by reset.
- `MIPS_CTRL_HALT_EN` undefined:
  - the HALT state is not built and `halted` is tied to 0.
  - `HALT_OPCODE` is treated as an illegal opcode and returns to FETCH.

## Structure
- Shared `alu_pkg` gains:
  - the `ctrl_state_t` enum
  - opcode constants `OP_LW`, `OP_SW`, `OP_ADDIU`, `OP_J`, `OP_JAL`, `OP_REGIMM`, `OP_HALT`
  - the existing `RTYPE` and `r_sel_t` are reused for funct decode
- Single module with separate next-state and output always blocks. No sub-module.

## Test plan
- Reset released with opcode `6'h00`, funct ADDU → INIT, FETCH (`pc_write`=1), FETCH_WAIT (`ir_write`=1), DECODE, R_EXEC (`alu_op`=0), R_WB (`reg_write`=1, `reg_dst`=1). Total 5 cycles after INIT.
- LW (`6'h23`) → MEM_RD (`i_or_d`=1), then MEM_WB (`mem_to_reg`=1, `reg_write`=1) on cycle 7. SW (`6'h2B`) → `mem_write`=1 for exactly one cycle on cycle 5.
- BEQ (`6'h04`) → BRANCH with `pc_write_cond`=1, `pc_source`=1, `alu_op`=`6'h04`. JAL (`6'h03`) → JUMP with `pc_write`=1, `jump_and_link`=1, `reg_write`=1.
- Funct JR (`6'h08`) → `pc_write`=1, `pc_source`=0 in R_EXEC, no `reg_write`. Funct MULT (`6'h18`) → FETCH after R_EXEC with no `reg_write`.
- Opcode `6'h3F`:
  - with `MIPS_CTRL_HALT_EN`: `halted`=1 held for 20 cycles.
  - without it: back to FETCH after DECODE.
  - Illegal `6'h3E`: FETCH after DECODE.
- `rst` pulsed asynchronously during MEM_WR → `mem_write` falls before the next edge, state is INIT, next instruction fetches normally.
